// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control-unit to datapath signal bundle
interface multicycle_ctrl_fsm_if #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
);
    logic [OP_W-1:0]     instr_op_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                pc_write_cond_o;
    logic                branch_ne_o;
    logic                i_or_d_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                ir_write_o;
    logic                mem_to_reg_o;
    logic                reg_dst_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [1:0]          pc_source_o;
    logic                illegal_o;
    logic [3:0]          state_o;
    logic [CNT_W-1:0]    instr_cnt_o;

    modport master (
        input  instr_op_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_o,
               state_o, instr_cnt_o
    );

    modport slave (
        output instr_op_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, illegal_o,
               state_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle MIPS control unit FSM with retired-instruction counter
module multicycle_ctrl_fsm #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    multicycle_ctrl_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] ALU_ADDI  = ALU_OP_W'(3'b101);
    localparam logic [ALU_OP_W-1:0] ALU_SLTI  = ALU_OP_W'(3'b110);

    state_t              state, state_next;
    logic [CNT_W-1:0]    instr_cnt;
    logic                retire;

    logic                pc_write, pc_write_cond, branch_ne, i_or_d;
    logic                mem_read, mem_write, ir_write, mem_to_reg;
    logic                reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]          alu_src_b, pc_source;
    logic [ALU_OP_W-1:0] alu_op;

    logic [OP_W-1:0]     op;
    logic                ready;

    assign op    = bus.instr_op_i;
    assign ready = bus.mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            instr_cnt <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next    = FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;
        illegal       = 1'b0;

        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = ready;
                pc_write   = ready;
                state_next = ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = 2'b11;
                case (op)
                    OP_R:            state_next = R_EXEC;
                    OP_LW, OP_SW:    state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_next = BRANCH;
                    OP_ADDI, OP_SLTI: state_next = I_EXEC;
                    OP_J:            state_next = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_LW) begin
                    state_next = MEM_RD;
                end else if (op == OP_SW) begin
                    state_next = MEM_WR;
                end else begin
                    state_next = FETCH;
                end
            end
            MEM_RD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                state_next = ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (ready) begin
                    retire = 1'b1;
                end else begin
                    state_next = MEM_WR;
                end
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (op == OP_BNE);
                retire        = 1'b1;
            end
            I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = (op == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
                state_next = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // In reset the datapath sees FETCH selects with every enable and request quiet
        if (rst_i) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b01;
            alu_op        = ALU_ADD;
            pc_source     = 2'b00;
            illegal       = 1'b0;
        end
    end

    assign bus.pc_write_o      = pc_write;
    assign bus.pc_write_cond_o = pc_write_cond;
    assign bus.branch_ne_o     = branch_ne;
    assign bus.i_or_d_o        = i_or_d;
    assign bus.mem_read_o      = mem_read;
    assign bus.mem_write_o     = mem_write;
    assign bus.ir_write_o      = ir_write;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.reg_dst_o       = reg_dst;
    assign bus.reg_write_o     = reg_write;
    assign bus.alu_src_a_o     = alu_src_a;
    assign bus.alu_src_b_o     = alu_src_b;
    assign bus.alu_op_o        = alu_op;
    assign bus.pc_source_o     = pc_source;
    assign bus.illegal_o       = illegal;
    assign bus.state_o         = state;
    assign bus.instr_cnt_o     = instr_cnt;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]       st;
        logic [5:0]       op;
        logic             rdy;
        logic             rst;
        logic [CNT_W-1:0] cnt;
        ctrl_t            ctrl;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.OP_W(6), .ALU_OP_W(3), .CNT_W(CNT_W)) bus ();

    multicycle_ctrl_fsm #(.OP_W(6), .ALU_OP_W(3), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    entry_t           sb[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               checks  = 0;
    int               passed  = 0;
    int               step    = 0;

    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                       input logic rdy, input logic rs);
        ctrl_t c;
        c = '0;
        if (rs) begin
            c.srcb = 2'b01;
            return c;
        end
        case (st)
            4'd0:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            4'd1:  begin c.srcb = 2'b11;
                         c.ill = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B}); end
            4'd2:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            4'd3:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            4'd4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            4'd5:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            4'd6:  begin c.srca = 1'b1; c.aluop = 3'b010; end
            4'd7:  begin c.rw = 1'b1; c.rdst = 1'b1; end
            4'd8:  begin c.srca = 1'b1; c.aluop = 3'b001; c.pcwc = 1'b1; c.pcsrc = 2'b01;
                         c.bne = (op == 6'h05); end
            4'd9:  begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = (op == 6'h0A) ? 3'b110 : 3'b101; end
            4'd10: c.rw = 1'b1;
            4'd11: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic rdy, input logic rs);
        entry_t e;
        e.st   = st;
        e.op   = op;
        e.rdy  = rdy;
        e.rst  = rs;
        e.cnt  = exp_cnt;
        e.ctrl = exp_ctrl(st, op, rdy, rs);
        sb.push_back(e);
    endtask

    task automatic drain();
        entry_t e;
        ctrl_t  obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.instr_op_i  = e.op;
            bus.mem_ready_i = e.rdy;
            rst             = e.rst;
            @(negedge clk);
            obs = {bus.pc_write_o, bus.pc_write_cond_o, bus.branch_ne_o, bus.i_or_d_o,
                   bus.mem_read_o, bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o,
                   bus.reg_dst_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                   bus.alu_op_o, bus.pc_source_o, bus.illegal_o};
            checks++;
            assert (bus.state_o === e.st) passed++;
            else $error("FAIL state step %0d: got %0d expected %0d", step, bus.state_o, e.st);
            checks++;
            assert (obs === e.ctrl) passed++;
            else $error("FAIL ctrl step %0d state %0d: got %h expected %h", step, e.st, obs, e.ctrl);
            checks++;
            assert (bus.instr_cnt_o === e.cnt) passed++;
            else $error("FAIL cnt step %0d: got %0d expected %0d", step, bus.instr_cnt_o, e.cnt);
            step++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.instr_op_i  = 6'h00;
        bus.mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset held: quiet enables, FETCH state, zero count
        push(4'd0, 6'h00, 1'b1, 1'b1);
        push(4'd0, 6'h00, 1'b1, 1'b1);
        drain();

        // R-type: 0,1,6,7
        push(4'd0, 6'h00, 1'b1, 1'b0); push(4'd1, 6'h00, 1'b1, 1'b0);
        push(4'd6, 6'h00, 1'b1, 1'b0); push(4'd7, 6'h00, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // lw with two stalled MEM_RD cycles
        push(4'd0, 6'h23, 1'b1, 1'b0); push(4'd1, 6'h23, 1'b1, 1'b0);
        push(4'd2, 6'h23, 1'b1, 1'b0); push(4'd3, 6'h23, 1'b0, 1'b0);
        push(4'd3, 6'h23, 1'b0, 1'b0); push(4'd3, 6'h23, 1'b1, 1'b0);
        push(4'd4, 6'h23, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // bne then beq
        push(4'd0, 6'h05, 1'b1, 1'b0); push(4'd1, 6'h05, 1'b1, 1'b0); push(4'd8, 6'h05, 1'b1, 1'b0);
        drain(); exp_cnt++;
        push(4'd0, 6'h04, 1'b1, 1'b0); push(4'd1, 6'h04, 1'b1, 1'b0); push(4'd8, 6'h04, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // addi then slti
        push(4'd0, 6'h08, 1'b1, 1'b0); push(4'd1, 6'h08, 1'b1, 1'b0);
        push(4'd9, 6'h08, 1'b1, 1'b0); push(4'd10, 6'h08, 1'b1, 1'b0);
        drain(); exp_cnt++;
        push(4'd0, 6'h0A, 1'b1, 1'b0); push(4'd1, 6'h0A, 1'b1, 1'b0);
        push(4'd9, 6'h0A, 1'b1, 1'b0); push(4'd10, 6'h0A, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // sw with a stalled FETCH and a stalled MEM_WR
        push(4'd0, 6'h2B, 1'b0, 1'b0); push(4'd0, 6'h2B, 1'b1, 1'b0);
        push(4'd1, 6'h2B, 1'b1, 1'b0); push(4'd2, 6'h2B, 1'b1, 1'b0);
        push(4'd5, 6'h2B, 1'b0, 1'b0); push(4'd5, 6'h2B, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // j
        push(4'd0, 6'h02, 1'b1, 1'b0); push(4'd1, 6'h02, 1'b1, 1'b0); push(4'd11, 6'h02, 1'b1, 1'b0);
        drain(); exp_cnt++;

        // Illegal opcode: flagged in DECODE, not retired
        push(4'd0, 6'h3F, 1'b1, 1'b0); push(4'd1, 6'h3F, 1'b1, 1'b0);
        drain();

        // Reset while stalled in MEM_WR aborts the store
        push(4'd0, 6'h2B, 1'b1, 1'b0); push(4'd1, 6'h2B, 1'b1, 1'b0);
        push(4'd2, 6'h2B, 1'b1, 1'b0); push(4'd5, 6'h2B, 1'b0, 1'b0);
        push(4'd5, 6'h2B, 1'b0, 1'b1);
        drain(); exp_cnt = '0;

        // 16 back-to-back jumps wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            push(4'd0, 6'h02, 1'b1, 1'b0); push(4'd1, 6'h02, 1'b1, 1'b0); push(4'd11, 6'h02, 1'b1, 1'b0);
            drain(); exp_cnt++;
        end
        push(4'd0, 6'h02, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
